// File: rtl/led_breath_if.sv
// Signal bundle for led_breath: run controls towards the block, LED drive and status back.
interface led_breath_if;
  logic       en;
  logic       mode;
  logic [7:0] duty_in;
  logic [1:0] led;
  logic [7:0] level;
  logic       period_start;

  modport master (output en, mode, duty_in, input led, level, period_start);
  modport slave  (input en, mode, duty_in, output led, level, period_start);
endinterface

// File: rtl/led_breath.sv
// LED breathing controller: 8-bit PWM driven by a rise/hold/fall envelope or a fixed duty.
// Define LED_BREATH_GAMMA_EN to square the level before it reaches the PWM comparator.
module led_breath #(
  parameter int unsigned PRESCALE     = 8,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned HOLD_PERIODS = 16
) (
  input  logic        clk,
  input  logic        rst,
  led_breath_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO} state_e;

  localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
  localparam logic [7:0]  STEP_LAST = 8'(STEP_PERIODS - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_PERIODS - 1);

  state_e      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  level_q, level_d;
  logic [7:0]  duty_act_q, duty_act_d;
  logic        pwm_q, pwm_d;
  logic        pstart_q, pstart_d;
  logic        tick, boundary;

  // NOTE: registers take non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      phase_q    <= '0;
      cnt_q      <= '0;
      level_q    <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
      pstart_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
      pstart_q   <= pstart_d;
    end
  end

  always_comb begin
    // NOTE: every value written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    pre_d      = pre_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    duty_act_d = duty_act_q;
    pstart_d   = 1'b0;
    tick       = (pre_q == PRE_LAST);
    boundary   = tick && (phase_q == 8'hFF);

    if (!bus.en) begin
      state_d    = IDLE;
      pre_d      = '0;
      phase_d    = '0;
      cnt_d      = '0;
      level_d    = '0;
      duty_act_d = '0;
    end else begin
      pre_d    = tick ? '0 : pre_q + 16'd1;
      phase_d  = tick ? phase_q + 8'd1 : phase_q;
      pstart_d = boundary;
      if (boundary) begin
        cnt_d = cnt_q + 8'd1;
        if (bus.mode) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = bus.duty_in;
        end else begin
          unique case (state_q)
            IDLE: begin
              state_d = RISE;
              cnt_d   = '0;
              level_d = '0;
            end
            RISE: if (cnt_q == STEP_LAST) begin
              cnt_d = '0;
              if (level_q != 8'hFF) level_d = level_q + 8'd1;
              if (level_q >= 8'hFE) state_d = HOLD_HI;
            end
            HOLD_HI: if (cnt_q == HOLD_LAST) begin
              cnt_d   = '0;
              state_d = FALL;
            end
            FALL: if (cnt_q == STEP_LAST) begin
              cnt_d = '0;
              if (level_q != 8'h00) level_d = level_q - 8'd1;
              if (level_q <= 8'h01) state_d = HOLD_LO;
            end
            HOLD_LO: if (cnt_q == HOLD_LAST) begin
              cnt_d   = '0;
              state_d = RISE;
            end
            default: begin
              state_d = IDLE;
              cnt_d   = '0;
              level_d = '0;
            end
          endcase
        end
        // The duty for the coming period follows the level it will display.
`ifdef LED_BREATH_GAMMA_EN
        duty_act_d = 8'((16'(level_d) * 16'(level_d)) >> 8);
`else
        duty_act_d = level_d;
`endif
      end
    end

    pwm_d = (phase_d < duty_act_d);
  end

  assign bus.led          = {pwm_q, ~pwm_q};
  assign bus.level        = level_q;
  assign bus.period_start = pstart_q;

endmodule

// File: tb/tb_led_breath.sv
// Bench for led_breath: two differently parameterised instances checked every cycle against a
// period-level arithmetic model, plus duty vectors and hand-written multi-cycle sequences.
module tb_led_breath;

  localparam int PA = 1, SA = 1, HA = 2;
  localparam int PB = 3, SB = 2, HB = 1;
  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_en, in_mode;
  logic [7:0] in_duty;

  led_breath_if bus_a ();
  led_breath_if bus_b ();

  assign bus_a.en = in_en;  assign bus_a.mode = in_mode;  assign bus_a.duty_in = in_duty;
  assign bus_b.en = in_en;  assign bus_b.mode = in_mode;  assign bus_b.duty_in = in_duty;

  led_breath #(.PRESCALE(PA), .STEP_PERIODS(SA), .HOLD_PERIODS(HA)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  led_breath #(.PRESCALE(PB), .STEP_PERIODS(SB), .HOLD_PERIODS(HB)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: actual %0h, required %0h", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  int mp[NI] = '{PA, PB};
  int ms[NI] = '{SA, SB};
  int mh[NI] = '{HA, HB};
  int m_t[NI], m_lvl[NI], m_duty[NI], m_k[NI];
  bit m_br[NI], m_ps[NI];
  bit mon_on = 1'b0;

  function automatic int gam(input int l);
`ifdef LED_BREATH_GAMMA_EN
    return (l * l) >> 8;
`else
    return l;
`endif
  endfunction

  // Level during the k-th period after breathing starts: ramp up, top plateau, ramp down, bottom.
  function automatic int breath_level(input int k, input int s, input int h);
    int r;
    r = k % (510 * s + 2 * h);
    if (r < 255 * s)           return r / s;
    if (r < 255 * s + h)       return 255;
    if (r < 510 * s + h)       return 255 - (r - 255 * s - h) / s;
    return 0;
  endfunction

  function automatic logic [10:0] model_out(input int i);
    logic pwm;
    pwm = ((m_t[i] / mp[i]) < m_duty[i]);
    return {pwm, ~pwm, 8'(m_lvl[i]), m_ps[i]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst || !in_en) begin
        m_t[i] = 0; m_lvl[i] = 0; m_duty[i] = 0; m_k[i] = 0; m_br[i] = 1'b0; m_ps[i] = 1'b0;
      end else begin
        m_ps[i] = (m_t[i] == 256 * mp[i] - 1);
        m_t[i]  = m_ps[i] ? 0 : m_t[i] + 1;
        if (m_ps[i]) begin
          if (in_mode) begin
            m_br[i] = 1'b0; m_lvl[i] = int'(in_duty);
          end else if (!m_br[i]) begin
            m_br[i] = 1'b1; m_k[i] = 0; m_lvl[i] = 0;
          end else begin
            m_k[i]++; m_lvl[i] = breath_level(m_k[i], ms[i], mh[i]);
          end
          m_duty[i] = gam(m_lvl[i]);
        end
      end
    end
    mon_on = 1'b1;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("cycle_a", 32'({bus_a.led, bus_a.level, bus_a.period_start}), 32'(model_out(0)));
      check("cycle_b", 32'({bus_b.led, bus_b.level, bus_b.period_start}), 32'(model_out(1)));
    end
  end

  // ---------------- helpers (instance A) ----------------
  task automatic wait_ps(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.period_start && n < 2 * 256 * PA + 4);
    check(name, 32'(bus_a.period_start), 32'd1);
  endtask

  task automatic measure_period(input int change_at, input logic [7:0] new_duty,
                                output int hi, output int pulses);
    hi = 0;
    pulses = 0;
    for (int c = 0; c < 256 * PA; c++) begin
      if (c > 0) @(negedge clk);
      if (c == change_at) in_duty = new_duty;
      hi     += int'(bus_a.led[1]);
      pulses += int'(bus_a.period_start);
    end
  endtask

  task automatic wait_level(input logic [7:0] v, input int bound, output int cycles);
    cycles = 0;
    while (bus_a.level !== v && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    check("level_reached", 32'(bus_a.level), 32'(v));
  endtask

  typedef struct {
    logic [7:0] duty;
    int         hi;
    int         hi_gamma;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   hi, pulses, cyc, exp_hi;

    vecs[0] = '{duty: 8'd64,  hi: 64,  hi_gamma: 16};
    vecs[1] = '{duty: 8'd0,   hi: 0,   hi_gamma: 0};
    vecs[2] = '{duty: 8'd255, hi: 255, hi_gamma: 254};
    vecs[3] = '{duty: 8'd1,   hi: 1,   hi_gamma: 0};
    vecs[4] = '{duty: 8'd128, hi: 128, hi_gamma: 64};
    vecs[5] = '{duty: 8'd254, hi: 254, hi_gamma: 252};

    rst = 1'b1; in_en = 1'b0; in_mode = 1'b0; in_duty = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_led",   32'(bus_a.led), 32'd1);
    check("reset_level", 32'(bus_a.level), 32'd0);
    check("reset_ps",    32'(bus_a.period_start), 32'd0);

    // Reset outranks a running, fixed-duty request.
    in_en = 1'b1; in_mode = 1'b1; in_duty = 8'd200;
    repeat (2) @(negedge clk);
    check("reset_prio_led",   32'(bus_a.led), 32'd1);
    check("reset_prio_level", 32'(bus_a.level), 32'd0);
    rst = 1'b0;

    // Fixed-duty vectors: duty sampled at a boundary, measured over the following period.
    for (int i = 0; i < 6; i++) begin
      in_duty = vecs[i].duty;
      wait_ps("fix_ps_seen");
      check("fix_level", 32'(bus_a.level), 32'(vecs[i].duty));
      measure_period(-1, 8'd0, hi, pulses);
`ifdef LED_BREATH_GAMMA_EN
      exp_hi = vecs[i].hi_gamma;
`else
      exp_hi = vecs[i].hi;
`endif
      check("fix_high_cycles", 32'(hi), 32'(exp_hi));
      check("fix_ps_pulses", 32'(pulses), 32'd1);
      @(negedge clk);
      check("fix_ps_spacing", 32'(bus_a.period_start), 32'd1);
    end

    // duty_in changes mid-period: current period keeps the old duty.
    in_duty = 8'd32;
    wait_ps("mid_ps_seen");
    measure_period(100, 8'd200, hi, pulses);
    check("mid_current", 32'(hi), 32'(gam(32)));
    @(negedge clk);
    measure_period(-1, 8'd0, hi, pulses);
    check("mid_next", 32'(hi), 32'(gam(200)));

    // Reset mid-period at fixed level 200.
    wait_ps("rst200_ps_seen");
    check("rst200_level_before", 32'(bus_a.level), 32'd200);
    repeat (77) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst200_led",   32'(bus_a.led), 32'd1);
    check("rst200_level", 32'(bus_a.level), 32'd0);
    check("rst200_ps",    32'(bus_a.period_start), 32'd0);
    rst = 1'b0;

    // Random segments, judged by the per-cycle model.
    for (int s = 0; s < 12; s++) begin
      in_en   = ($urandom_range(0, 9) != 0);
      in_mode = 1'($urandom_range(0, 1));
      in_duty = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 400)) @(negedge clk);
    end

    // Breathing from reset: one IDLE period, then 255 one-period steps up to the top.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_en = 1'b1; in_mode = 1'b0;
    wait_level(8'd255, 70000, cyc);
    check("ramp_cycles", 32'(cyc), 32'(256 * PA * (1 + 255 * SA)));
    // 255 stays for the HOLD_HI periods plus the first STEP_PERIODS of FALL, then steps to 254.
    wait_level(8'd254, 4000, cyc);
    check("top_cycles", 32'(cyc), 32'(256 * PA * (HA + SA)));

    // en drops mid-period during FALL, then breathing restarts from the next boundary.
    wait_level(8'd250, 4000, cyc);
    repeat (77) @(negedge clk);
    in_en = 1'b0;
    @(negedge clk);
    check("endrop_led",   32'(bus_a.led), 32'd1);
    check("endrop_level", 32'(bus_a.level), 32'd0);
    in_en = 1'b1;
    wait_ps("rerise_ps_seen");
    check("rerise_level0", 32'(bus_a.level), 32'd0);
    wait_ps("rerise_ps_seen2");
    check("rerise_level1", 32'(bus_a.level), 32'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
